sd_rx_fifo: RTL and testbench

- Byte buffer directly downstream of the SD-card block reader.
- Accepts the reader's byte output (8-bit data plus a push level that is high for a whole slow SPI-clock period) on the fast system clock, converting each push pulse into exactly one write.
- Presents a first-word-fall-through (FWFT) pop interface to the consumer, e.g. the display or UART sink.
- Flags overflow, since the reader has no back-pressure input.

---
 rtl/sd_pkg.sv | 6 +
 rtl/sd_edge_detect.sv | 17 +
 rtl/sd_rx_fifo.sv | 98 +++++++++
 tb/tb_sd_rx_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants for the SD-card read path (block reader and its byte FIFO).
package sd_pkg;
    localparam int SD_BYTE_W              = 8;
    localparam int SD_BLOCK_BYTES         = 512;
    localparam int SD_FIFO_ADDR_W_DEFAULT = 10;
endpackage

// File: rtl/sd_edge_detect.sv
// Registered rising-edge detector for a slow-clock strobe sampled on clock.
// Resets its history to 1 so a level already high at reset release gives no edge.
module sd_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic level_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) level_d <= 1'b1;
        else       level_d <= level;
    end

    assign rise = level & ~level_d;
endmodule

// File: rtl/sd_rx_fifo.sv
// FWFT byte FIFO behind the SD block reader; one write per push_in rising edge, sticky overflow.
// Define SD_FIFO_ALMOST_FULL_EN to add the almost_full output (count >= AFULL_LEVEL).
module sd_rx_fifo
    import sd_pkg::*;
#(
    parameter int ADDR_WIDTH = SD_FIFO_ADDR_W_DEFAULT,
    parameter int DATA_WIDTH = SD_BYTE_W
`ifdef SD_FIFO_ALMOST_FULL_EN
    ,
    parameter int AFULL_LEVEL = 1000
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
`ifdef SD_FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push_event;
    logic                  wr_en;
    logic                  rd_en;

    sd_edge_detect u_push_edge (
        .clock (clock),
        .reset (reset),
        .level (push_in),
        .rise  (push_event)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push with pop.
    always_comb begin
        rd_en      = pop && !empty;
        wr_en      = push_event && (!full || rd_en);
        count_next = count;
        if (clear)
            count_next = '0;
        else if (wr_en && !rd_en)
            count_next = count + 1'b1;
        else if (rd_en && !wr_en)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
                if (push_event && full && !rd_en) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !clear) mem[wr_ptr] <= data_in;
    end

    assign data_out = empty ? '0 : mem[rd_ptr];

`ifdef SD_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_COUNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) almost_full <= 1'b0;
        else       almost_full <= (count_next >= AFULL_COUNT);
    end
`endif
endmodule

// File: tb/tb_sd_rx_fifo.sv
// Self-checking bench for sd_rx_fifo against a queue-based reference model.
module tb_sd_rx_fifo;
    import sd_pkg::*;

    localparam int AW    = SD_FIFO_ADDR_W_DEFAULT;
    localparam int DW    = SD_BYTE_W;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          push_in;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
`ifdef SD_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    sd_rx_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push_in  (push_in),
        .data_in  (data_in),
        .pop      (pop),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef SD_FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stored bytes in order, sticky overflow, previous push level.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_push_d;

    function automatic logic [DW-1:0] exp_head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    function automatic logic [AW:0] exp_count();
        return (AW+1)'(q.size());
    endfunction

    // Apply the current inputs to the model, then advance one clock and settle.
    task automatic tick();
        bit ev;
        bit do_pop;
        ev     = push_in && !m_push_d;
        do_pop = pop && (q.size() != 0);
        if (clear) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back(data_in);
                else                  m_ovf = 1'b1;
            end
        end
        m_push_d = push_in;
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        data_in = b;
        push_in = 1'b1;
        tick();
        push_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clear   = 1'b0;
        push_in = 1'b1;
        pop     = 1'b0;
        data_in = 8'h77;
        q.delete();
        m_ovf    = 1'b0;
        m_push_d = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({empty, full, overflow} !== 3'b100 || count !== '0 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_state: empty/full/ovf=%b%b%b count=%0d data=%h, want 100 0 00",
                     empty, full, overflow, count, data_out);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (count !== '0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL push_held_through_reset: count=%0d empty=%b, want 0 1", count, empty);
        end
        push_in = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        data_in = 8'hA5;
        push_in = 1'b1;
        tick();
        n_cmp++;
        if (data_out !== 8'hA5 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: data=%h empty=%b, want a5 0", data_out, empty);
        end
        repeat (124) tick();
        n_cmp++;
        if (count !== 1 || count !== exp_count()) begin
            n_err++;
            $display("FAIL single_long_pulse: count=%0d, want 1", count);
        end
        push_in = 1'b0;
        pop     = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++;
        if (empty !== 1'b1 || count !== '0 || data_out !== '0) begin
            n_err++;
            $display("FAIL single_pop: empty=%b count=%0d data=%h, want 1 0 00", empty, count, data_out);
        end
    endtask

    task automatic drain_and_check(input string tag);
        int bad = 0;
        while (q.size() != 0 && bad < 4) begin
            n_cmp++;
            if (data_out !== exp_head() || count !== exp_count()) begin
                n_err++;
                bad++;
                $display("FAIL %s_drain: data=%h count=%0d, want %h %0d",
                         tag, data_out, count, exp_head(), exp_count());
            end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== '0) begin
            n_err++;
            $display("FAIL %s_empty_after_drain: empty=%b count=%0d, want 1 0", tag, empty, count);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < SD_BLOCK_BYTES; i++) push_byte(DW'(i));
        n_cmp++;
        if (count !== exp_count() || count !== (AW+1)'(SD_BLOCK_BYTES)) begin
            n_err++;
            $display("FAIL stream_count: count=%0d, want %0d", count, SD_BLOCK_BYTES);
        end
        drain_and_check("stream");
        // Second pass longer than the depth, with interleaved pops, exercises pointer wrap.
        for (int i = 0; i < 1100; i++) begin
            data_in = DW'($urandom);
            push_in = 1'b1;
            pop     = ($urandom_range(0, 2) == 0);
            tick();
            push_in = 1'b0;
            pop     = 1'b0;
            tick();
        end
        n_cmp++;
        if (count !== exp_count() || data_out !== exp_head()) begin
            n_err++;
            $display("FAIL wrap_state: count=%0d data=%h, want %0d %h",
                     count, data_out, exp_count(), exp_head());
        end
        drain_and_check("wrap");
    endtask

    task automatic test_overflow();
        logic [DW-1:0] head;
        for (int i = 0; i < DEPTH; i++) push_byte(DW'($urandom));
        head = exp_head();
        n_cmp++;
        if (full !== 1'b1 || count !== (AW+1)'(DEPTH) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: full=%b count=%0d ovf=%b, want 1 %0d 0", full, count, overflow, DEPTH);
        end
        push_byte(8'h3C);
        n_cmp++;
        if (count !== (AW+1)'(DEPTH) || overflow !== 1'b1 || data_out !== head || !m_ovf) begin
            n_err++;
            $display("FAIL overflow_drop: count=%0d ovf=%b data=%h, want %0d 1 %h",
                     count, overflow, data_out, DEPTH, head);
        end
        data_in = 8'hC3;
        push_in = 1'b1;
        pop     = 1'b1;
        tick();
        push_in = 1'b0;
        pop     = 1'b0;
        n_cmp++;
        if (count !== (AW+1)'(DEPTH) || full !== 1'b1 || data_out !== exp_head()) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d full=%b data=%h, want %0d 1 %h",
                     count, full, data_out, DEPTH, exp_head());
        end
        tick();
        drain_and_check("overflow");
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: ovf=%b, want 1", overflow);
        end
    endtask

    task automatic test_empty_ops();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++;
        if (count !== '0 || empty !== 1'b1 || data_out !== '0) begin
            n_err++;
            $display("FAIL pop_empty: count=%0d empty=%b data=%h, want 0 1 00", count, empty, data_out);
        end
        data_in = 8'h5E;
        push_in = 1'b1;
        pop     = 1'b1;
        tick();
        push_in = 1'b0;
        pop     = 1'b0;
        n_cmp++;
        if (count !== 1 || data_out !== 8'h5E || count !== exp_count()) begin
            n_err++;
            $display("FAIL push_pop_empty: count=%0d data=%h, want 1 5e", count, data_out);
        end
        tick();
    endtask

    task automatic test_clear();
        while (q.size() < 7) push_byte(DW'($urandom));
        n_cmp++;
        if (count !== 7 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL pre_clear: count=%0d ovf=%b, want 7 1", count, overflow);
        end
        data_in = 8'h99;
        push_in = 1'b1;
        pop     = 1'b1;
        clear   = 1'b1;
        tick();
        clear = 1'b0;
        pop   = 1'b0;
        n_cmp++;
        if (count !== '0 || overflow !== 1'b0 || empty !== 1'b1 || data_out !== '0) begin
            n_err++;
            $display("FAIL clear_priority: count=%0d ovf=%b empty=%b data=%h, want 0 0 1 00",
                     count, overflow, empty, data_out);
        end
        repeat (4) tick();
        n_cmp++;
        if (count !== '0 || count !== exp_count()) begin
            n_err++;
            $display("FAIL clear_held_push: count=%0d, want 0", count);
        end
        push_in = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int hold = 0;
        int bad  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                push_in = ~push_in;
                hold    = $urandom_range(1, 6);
                if (push_in) data_in = DW'($urandom);
            end
            hold--;
            pop   = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 499) == 0);
            tick();
            if (bad < 6) begin
                n_cmp++;
                if (count !== exp_count() || data_out !== exp_head() || empty !== (q.size() == 0) ||
                    full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
                    n_err++;
                    bad++;
                    $display("FAIL random_cycle%0d: count=%0d data=%h e/f/o=%b%b%b, want %0d %h %b%b%b",
                             i, count, data_out, empty, full, overflow, exp_count(), exp_head(),
                             q.size() == 0, q.size() == DEPTH, m_ovf);
                end
`ifdef SD_FIFO_ALMOST_FULL_EN
                n_cmp++;
                if (almost_full !== (q.size() >= 1000)) begin
                    n_err++;
                    bad++;
                    $display("FAIL random_afull%0d: afull=%b, want %b", i, almost_full, q.size() >= 1000);
                end
`endif
            end
        end
        push_in = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_stream();
        test_overflow();
        test_empty_ops();
        test_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
